multicycle_controller: RTL and testbench

//  FSM that sequences the ARM datapath over several cycles per instruction.
//  A single memory port and a single ALU are time-shared between fetch, address generation and execute.

---
 rtl/multicycle_controller.sv | 265 ++++++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// ============================================================================
// multicycle_controller
// ----------------------------------------------------------------------------
// Control FSM for a multicycle ARM-subset datapath. One memory port and one
// ALU are shared between fetch, address generation and execute, so each
// instruction takes several cycles. The controller decodes the latched
// instruction, holds the NZCV flags, evaluates the condition field and drives
// every mux select and write enable of the datapath.
//
// Parameters
//   MEM_WAIT    extra wait cycles spent in FETCH and MEMREAD (0..15)
//
// Ports
//   clk         in   rising-edge clock
//   reset_n     in   asynchronous reset, active low
//   instr       in   latched instruction ([31:28] cond, [27:26] op,
//                    [25:20] funct, [15:12] rd)
//   alu_flags   in   {n,z,c,v} from the ALU in the current cycle
//   pc_write    out  PC load enable
//   ir_write    out  instruction register load enable
//   adr_src     out  memory address select (0 pc, 1 alu_out)
//   mem_write   out  data memory write enable
//   reg_write   out  register file write enable
//   alu_src_a   out  ALU A select (0 rd1, 1 pc)
//   alu_src_b   out  ALU B select (00 rd2, 01 ext_imm, 10 const 4)
//   result_src  out  result select (00 alu_out, 01 data, 10 alu_result)
//   imm_src     out  extender mode (= op)
//   reg_src     out  [1] r15 as addr1 for branches, [0] rd as addr2 for memory
//   alu_ctl     out  00 add, 01 sub, 10 and, 11 orr
//   state_o     out  current state (debug / verification)
// ============================================================================
module multicycle_controller #(
    parameter int MEM_WAIT = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] instr,
    input  logic [3:0]  alu_flags,
    output logic        pc_write,
    output logic        ir_write,
    output logic        adr_src,
    output logic        mem_write,
    output logic        reg_write,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  result_src,
    output logic [1:0]  imm_src,
    output logic [1:0]  reg_src,
    output logic [1:0]  alu_ctl,
    output logic [3:0]  state_o
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

    // ARM condition-code evaluation against {n,z,c,v}
    function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] flags);
        logic n, z, c, v;
        logic res;
        {n, z, c, v} = flags;
        case (cond)
            4'b0000: res = z;
            4'b0001: res = ~z;
            4'b0010: res = c;
            4'b0011: res = ~c;
            4'b0100: res = n;
            4'b0101: res = ~n;
            4'b0110: res = v;
            4'b0111: res = ~v;
            4'b1000: res = c & ~z;
            4'b1001: res = ~c | z;
            4'b1010: res = (n == v);
            4'b1011: res = (n != v);
            4'b1100: res = ~z & (n == v);
            4'b1101: res = z | (n != v);
            4'b1110: res = 1'b1;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    // Data-processing command decode: returns {arith, no_write, alu_ctl[1:0]}
    function automatic logic [3:0] cmd_decode(input logic [3:0] cmd);
        logic [3:0] res;
        case (cmd)
            4'b0100: res = {1'b1, 1'b0, 2'b00};  // ADD
            4'b0010: res = {1'b1, 1'b0, 2'b01};  // SUB
            4'b0000: res = {1'b0, 1'b0, 2'b10};  // AND
            4'b1100: res = {1'b0, 1'b0, 2'b11};  // ORR
            4'b1010: res = {1'b1, 1'b1, 2'b01};  // CMP: subtract, flags only
            default: res = {1'b0, 1'b1, 2'b00};  // unsupported: harmless no-op
        endcase
        return res;
    endfunction

    state_t      state_r;
    state_t      state_next_s;
    logic [3:0]  cnt_r;
    logic [3:0]  flags_r;
    logic        cond_ex_s;
    logic        wait_done_s;
    logic [1:0]  op_s;
    logic [5:0]  funct_s;
    logic        rd_is_pc_s;
    logic [3:0]  dp_s;
    logic        dp_arith_s;
    logic        dp_no_write_s;
    logic [1:0]  dp_ctl_s;
    logic        pc_write_s;
    logic        ir_write_s;
    logic        mem_write_s;
    logic        reg_write_s;
    logic        unused_s;

    assign op_s          = instr[27:26];
    assign funct_s       = instr[25:20];
    assign rd_is_pc_s    = (instr[15:12] == 4'd15);
    assign dp_s          = cmd_decode(funct_s[4:1]);
    assign dp_arith_s    = dp_s[3];
    assign dp_no_write_s = dp_s[2];
    assign dp_ctl_s      = dp_s[1:0];
    assign cond_ex_s     = cond_eval(instr[31:28], flags_r);
    assign wait_done_s   = (cnt_r == WAIT_LAST);
    assign unused_s      = ^{instr[19:16], instr[11:0]};

    assign imm_src = op_s;
    assign reg_src = {(op_s == 2'b10), (op_s == 2'b01)};
    assign state_o = state_r;

    // Write enables are forced low while reset is held so no partial write escapes
    assign pc_write  = pc_write_s  & reset_n;
    assign ir_write  = ir_write_s  & reset_n;
    assign mem_write = mem_write_s & reset_n;
    assign reg_write = reg_write_s & reset_n;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Wait counter: cleared on entry to FETCH/MEMREAD, counts (saturating) while there
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r <= 4'd0;
        end else if (((state_next_s == S_FETCH) || (state_next_s == S_MEMREAD)) &&
                     (state_next_s != state_r)) begin
            cnt_r <= 4'd0;
        end else if (((state_r == S_FETCH) || (state_r == S_MEMREAD)) && (cnt_r != 4'hF)) begin
            cnt_r <= cnt_r + 4'd1;
        end
    end

    // NZCV register: written at the end of execute for S-suffixed, condition-passing ops
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags_r <= 4'b0000;
        end else if (((state_r == S_EXECUTER) || (state_r == S_EXECUTEI)) &&
                     funct_s[0] && cond_ex_s) begin
            flags_r[3:2] <= alu_flags[3:2];
            if (dp_arith_s) begin
                flags_r[1:0] <= alu_flags[1:0];
            end
        end
    end

    // Next-state logic and datapath control decode
    always_comb begin
        state_next_s = S_FETCH;
        pc_write_s   = 1'b0;
        ir_write_s   = 1'b0;
        mem_write_s  = 1'b0;
        reg_write_s  = 1'b0;
        adr_src      = 1'b0;
        alu_src_a    = 1'b0;
        alu_src_b    = 2'b00;
        result_src   = 2'b00;
        alu_ctl      = 2'b00;
        case (state_r)
            S_FETCH: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                if (wait_done_s) begin
                    ir_write_s   = 1'b1;
                    pc_write_s   = 1'b1;
                    state_next_s = S_DECODE;
                end else begin
                    state_next_s = S_FETCH;
                end
            end
            S_DECODE: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                case (op_s)
                    2'b00:   state_next_s = funct_s[5] ? S_EXECUTEI : S_EXECUTER;
                    2'b01:   state_next_s = S_MEMADR;
                    2'b10:   state_next_s = S_BRANCH;
                    default: state_next_s = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                alu_src_b    = 2'b01;
                state_next_s = funct_s[0] ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src      = 1'b1;
                state_next_s = wait_done_s ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                result_src   = 2'b01;
                reg_write_s  = cond_ex_s;
                pc_write_s   = cond_ex_s & rd_is_pc_s;
                state_next_s = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src      = 1'b1;
                mem_write_s  = cond_ex_s;
                state_next_s = S_FETCH;
            end
            S_EXECUTER: begin
                alu_src_b    = 2'b00;
                alu_ctl      = dp_ctl_s;
                state_next_s = S_ALUWB;
            end
            S_EXECUTEI: begin
                alu_src_b    = 2'b01;
                alu_ctl      = dp_ctl_s;
                state_next_s = S_ALUWB;
            end
            S_ALUWB: begin
                result_src   = 2'b00;
                reg_write_s  = cond_ex_s & ~dp_no_write_s;
                pc_write_s   = cond_ex_s & ~dp_no_write_s & rd_is_pc_s;
                state_next_s = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_b    = 2'b01;
                result_src   = 2'b10;
                pc_write_s   = cond_ex_s;
                state_next_s = S_FETCH;
            end
            default: begin
                state_next_s = S_FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// ============================================================================
// tb_multicycle_controller
// ----------------------------------------------------------------------------
// Scoreboard bench: the stimulus thread pushes one expected control word per
// cycle; a monitor pops and compares it on the falling edge (or immediately
// on an explicit sample event for asynchronous-reset checks).
// Two instances: MEM_WAIT = 0 for the main instruction set and MEM_WAIT = 2
// for the wait-state LDR sequence.
// ============================================================================
module tb_multicycle_controller;

    localparam logic [3:0] FETCH    = 4'd0;
    localparam logic [3:0] DECODE   = 4'd1;
    localparam logic [3:0] MEMADR   = 4'd2;
    localparam logic [3:0] MEMREAD  = 4'd3;
    localparam logic [3:0] MEMWB    = 4'd4;
    localparam logic [3:0] MEMWRITE = 4'd5;
    localparam logic [3:0] EXR      = 4'd6;
    localparam logic [3:0] EXI      = 4'd7;
    localparam logic [3:0] ALUWB    = 4'd8;
    localparam logic [3:0] BRANCH   = 4'd9;

    typedef struct packed {
        logic        d;
        logic [23:0] v;
    } rec_t;

    logic        clk;
    logic        reset_n;
    logic [31:0] instr;
    logic [3:0]  alu_flags;

    logic        pcw0, irw0, adr0, mw0, rw0, a0;
    logic [1:0]  b0, r0, imm0, rs0, alu0;
    logic [3:0]  st0;
    logic        pcw2, irw2, adr2, mw2, rw2, a2;
    logic [1:0]  b2, r2, imm2, rs2, alu2;
    logic [3:0]  st2;
    logic [23:0] act0, act2;

    rec_t        exp_q[$];
    string       name_q[$];
    int          checks;
    int          passed;
    event        sample_ev;

    multicycle_controller #(.MEM_WAIT(0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .instr(instr), .alu_flags(alu_flags),
        .pc_write(pcw0), .ir_write(irw0), .adr_src(adr0), .mem_write(mw0),
        .reg_write(rw0), .alu_src_a(a0), .alu_src_b(b0), .result_src(r0),
        .imm_src(imm0), .reg_src(rs0), .alu_ctl(alu0), .state_o(st0)
    );

    multicycle_controller #(.MEM_WAIT(2)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .instr(instr), .alu_flags(alu_flags),
        .pc_write(pcw2), .ir_write(irw2), .adr_src(adr2), .mem_write(mw2),
        .reg_write(rw2), .alu_src_a(a2), .alu_src_b(b2), .result_src(r2),
        .imm_src(imm2), .reg_src(rs2), .alu_ctl(alu2), .state_o(st2)
    );

    assign act0 = {st0, pcw0, irw0, adr0, mw0, rw0, a0, b0, r0, imm0, rs0, alu0, u_dut0.flags_r};
    assign act2 = {st2, pcw2, irw2, adr2, mw2, rw2, a2, b2, r2, imm2, rs2, alu2, u_dut2.flags_r};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Queue one expected control word; selects come from the per-state table
    task automatic push(input bit d, input string nm, input logic [3:0] st,
                        input logic pcw, input logic irw, input logic mw, input logic rw,
                        input logic [1:0] alu, input logic [3:0] fl, input logic [3:0] af);
        logic       adr, a;
        logic [1:0] b, r, op;
        rec_t       rec;
        alu_flags = af;
        op  = instr[27:26];
        adr = 1'b0; a = 1'b0; b = 2'b00; r = 2'b00;
        case (st)
            FETCH:    begin a = 1'b1; b = 2'b10; r = 2'b10; end
            DECODE:   begin a = 1'b1; b = 2'b10; r = 2'b10; end
            MEMADR:   b = 2'b01;
            MEMREAD:  adr = 1'b1;
            MEMWB:    r = 2'b01;
            MEMWRITE: adr = 1'b1;
            EXI:      b = 2'b01;
            BRANCH:   begin b = 2'b01; r = 2'b10; end
            default:  ;
        endcase
        rec.d = d;
        rec.v = {st, pcw, irw, adr, mw, rw, a, b, r, op,
                 {(op == 2'b10), (op == 2'b01)}, alu, fl};
        exp_q.push_back(rec);
        name_q.push_back(nm);
    endtask

    task automatic step(input bit d, input string nm, input logic [3:0] st,
                        input logic pcw, input logic irw, input logic mw, input logic rw,
                        input logic [1:0] alu, input logic [3:0] fl, input logic [3:0] af);
        push(d, nm, st, pcw, irw, mw, rw, alu, fl, af);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare the oldest expectation with the selected DUT
    initial begin
        rec_t        rec;
        string       nm;
        logic [23:0] act;
        forever begin
            @(negedge clk or sample_ev);
            if (exp_q.size() > 0) begin
                rec = exp_q.pop_front();
                nm  = name_q.pop_front();
                act = rec.d ? act2 : act0;
                checks++;
                if (act !== rec.v) begin
                    $display("FAIL %s (dut%0d): got %h expected %h", nm, rec.d ? 2 : 0, act, rec.v);
                end else begin
                    passed++;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passed, checks);
        $fatal(1);
    end

    initial begin
        checks    = 0;
        passed    = 0;
        reset_n   = 1'b0;
        instr     = 32'h0000_0000;
        alu_flags = 4'b0000;
        @(posedge clk);
        #1;
        // Reset state on both instances
        step(1'b0, "reset_dut0", FETCH, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'b0000, 4'b0000);
        step(1'b1, "reset_dut2", FETCH, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'b0000, 4'b0000);

        // LDR r4,[r5,#8] on the MEM_WAIT = 2 instance
        instr   = 32'hE595_4008;
        reset_n = 1'b1;
        step(1'b1, "ldr_fetch0", FETCH,   1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'b0000, 4'b0000);
        step(1'b1, "ldr_fetch1", FETCH,   1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'b0000, 4'b0000);
        step(1'b1, "ldr_fetch2", FETCH,   1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 4'b0000, 4'b0000);
        step(1'b1, "ldr_decode", DECODE,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'b0000, 4'b0000);
        step(1'b1, "ldr_memadr", MEMADR,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'b0000, 4'b0000);
        step(1'b1, "ldr_rd0",    MEMREAD, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'b0000, 4'b0000);
        step(1'b1, "ldr_rd1",    MEMREAD, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'b0000, 4'b0000);
        step(1'b1, "ldr_rd2",    MEMREAD, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'b0000, 4'b0000);
        step(1'b1, "ldr_memwb",  MEMWB,   1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 4'b0000, 4'b0000);
        step(1'b1, "ldr_next",   FETCH,   1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'b0000, 4'b0000);

        // Resynchronise both instances
        reset_n = 1'b0;
        instr   = 32'h0000_0000;
        step(1'b0, "reset_again", FETCH, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'b0000, 4'b0000);
        reset_n = 1'b1;

        // ADD r1,r2,r3
        instr = 32'hE082_1003;
        step(1'b0, "add_fetch",  FETCH,  1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 4'b0000, 4'b0000);
        step(1'b0, "add_decode", DECODE, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'b0000, 4'b0000);
        step(1'b0, "add_exr",    EXR,    1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'b0000, 4'b1111);
        step(1'b0, "add_aluwb",  ALUWB,  1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 4'b0000, 4'b0000);

        // SUBS r0,r0,#1 producing Z
        instr = 32'hE250_0001;
        step(1'b0, "subs_fetch",  FETCH,  1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 4'b0000, 4'b0000);
        step(1'b0, "subs_decode", DECODE, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'b0000, 4'b0000);
        step(1'b0, "subs_exi",    EXI,    1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 4'b0000, 4'b0100);
        step(1'b0, "subs_aluwb",  ALUWB,  1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 4'b0100, 4'b0000);

        // BEQ taken
        instr = 32'h0A00_0002;
        step(1'b0, "beq_t_fetch",  FETCH,  1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 4'b0100, 4'b0000);
        step(1'b0, "beq_t_decode", DECODE, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'b0100, 4'b0000);
        step(1'b0, "beq_t_branch", BRANCH, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 4'b0100, 4'b0000);

        // ADDS r1,r1,r1 clearing all flags
        instr = 32'hE091_1001;
        step(1'b0, "adds_fetch",  FETCH,  1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 4'b0100, 4'b0000);
        step(1'b0, "adds_decode", DECODE, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'b0100, 4'b0000);
        step(1'b0, "adds_exr",    EXR,    1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'b0100, 4'b0000);
        step(1'b0, "adds_aluwb",  ALUWB,  1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 4'b0000, 4'b0000);

        // BEQ not taken
        instr = 32'h0A00_0002;
        step(1'b0, "beq_n_fetch",  FETCH,  1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 4'b0000, 4'b0000);
        step(1'b0, "beq_n_decode", DECODE, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'b0000, 4'b0000);
        step(1'b0, "beq_n_branch", BRANCH, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'b0000, 4'b0000);

        // CMP r1,r2: flags only, no register write
        instr = 32'hE151_0002;
        step(1'b0, "cmp_fetch",  FETCH,  1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 4'b0000, 4'b0000);
        step(1'b0, "cmp_decode", DECODE, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'b0000, 4'b0000);
        step(1'b0, "cmp_exr",    EXR,    1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 4'b0000, 4'b0110);
        step(1'b0, "cmp_aluwb",  ALUWB,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'b0110, 4'b0000);

        // STRNE with Z set: MEMWRITE reached but suppressed
        instr = 32'h1585_4008;
        step(1'b0, "strne_fetch",  FETCH,    1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 4'b0110, 4'b0000);
        step(1'b0, "strne_decode", DECODE,   1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'b0110, 4'b0000);
        step(1'b0, "strne_memadr", MEMADR,   1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'b0110, 4'b0000);
        step(1'b0, "strne_memwr",  MEMWRITE, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'b0110, 4'b0000);

        // STR (always) with reset pulsed in MEMWRITE
        instr = 32'hE585_4008;
        step(1'b0, "str_fetch",  FETCH,  1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 4'b0110, 4'b0000);
        step(1'b0, "str_decode", DECODE, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'b0110, 4'b0000);
        step(1'b0, "str_memadr", MEMADR, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'b0110, 4'b0000);
        push(1'b0, "str_memwr",  MEMWRITE, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 4'b0110, 4'b0000);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        push(1'b0, "str_async_reset", FETCH, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'b0000, 4'b0000);
        -> sample_ev;
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Undefined op = 11: FETCH, DECODE, back to FETCH
        instr = 32'hEC00_0000;
        step(1'b0, "op11_fetch",  FETCH,  1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 4'b0000, 4'b0000);
        step(1'b0, "op11_decode", DECODE, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'b0000, 4'b0000);

        // ADD r15,r2,r3: write-back also loads the PC
        instr = 32'hE082_F003;
        step(1'b0, "addpc_fetch",  FETCH,  1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 4'b0000, 4'b0000);
        step(1'b0, "addpc_decode", DECODE, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'b0000, 4'b0000);
        step(1'b0, "addpc_exr",    EXR,    1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'b0000, 4'b0000);
        step(1'b0, "addpc_aluwb",  ALUWB,  1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 4'b0000, 4'b0000);
        step(1'b0, "addpc_next",   FETCH,  1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 4'b0000, 4'b0000);

        repeat (2) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end else begin
            passed++;
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
